// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone classic core bus.
// Imported by the interconnect and its address matcher.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } wb_state_e;

    localparam logic ERR_UNMAPPED = 1'b0;
    localparam logic ERR_TIMEOUT  = 1'b1;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational base/mask address matcher; lowest matching
// slave index wins when windows overlap.
module wb_addr_match
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int IDX_W      = 2,
    parameter logic [NUM_SLAVES*WB_ADR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*WB_ADR_W-1:0] SLV_MASK = '0
) (
    input  logic [WB_ADR_W-1:0] adr_i,
    output logic                any_hit_o,
    output logic [IDX_W-1:0]    hit_idx_o
);

    // Walk downwards so the lowest index is written last.
    always_comb begin
        any_hit_o = 1'b0;
        hit_idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (((adr_i ^ SLV_BASE[WB_ADR_W*i +: WB_ADR_W])
                 & SLV_MASK[WB_ADR_W*i +: WB_ADR_W]) == '0) begin
                any_hit_o = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// 1-master to N-slave Wishbone classic interconnect with
// unmapped-address errors, ack watchdog and sticky error log.
module wb_interconnect
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*WB_ADR_W-1:0] SLV_BASE =
        {32'h0201_0000, 32'h0200_0000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*WB_ADR_W-1:0] SLV_MASK =
        {32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_8000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_cyc_i,
    input  logic                           m_stb_i,
    input  logic                           m_we_i,
    input  logic [WB_SEL_W-1:0]            m_sel_i,
    input  logic [WB_ADR_W-1:0]            m_adr_i,
    input  logic [WB_DAT_W-1:0]            m_dat_i,
    output logic [WB_DAT_W-1:0]            m_dat_o,
    output logic                           m_ack_o,
    output logic                           m_err_o,
    output logic [NUM_SLAVES-1:0]          s_cyc_o,
    output logic [NUM_SLAVES-1:0]          s_stb_o,
    output logic                           s_we_o,
    output logic [WB_SEL_W-1:0]            s_sel_o,
    output logic [WB_ADR_W-1:0]            s_adr_o,
    output logic [WB_DAT_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES*WB_DAT_W-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    output logic                           err_valid_o,
    output logic                           err_code_o,
    output logic [WB_ADR_W-1:0]            err_adr_o,
    input  logic                           err_clr_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    wb_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [WB_ADR_W-1:0]  adr_q, adr_d;
    logic                 err_valid_q, err_valid_d;
    logic                 err_code_q, err_code_d;
    logic [WB_ADR_W-1:0]  err_adr_q, err_adr_d;

    logic                 any_hit;
    logic [IDX_W-1:0]     hit_idx;
    logic [IDX_W-1:0]     sel;
    logic                 req;
    logic                 route;
    logic                 ack_sel;
    logic [WB_DAT_W-1:0]  dat_sel;
    logic                 log_err;
    logic                 log_code;
    logic [WB_ADR_W-1:0]  log_adr;

    wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_match (
        .adr_i      (m_adr_i),
        .any_hit_o  (any_hit),
        .hit_idx_o  (hit_idx)
    );

    assign s_we_o  = m_we_i;
    assign s_sel_o = m_sel_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;

    assign req = m_cyc_i & m_stb_i;
    assign sel = (state_q == BUSY) ? sel_q : hit_idx;

    // Reset gates the routed outputs so an aborted cycle never terminates.
    assign route = !rst &&
        ((state_q == IDLE && req && any_hit) || state_q == BUSY);

    always_comb begin
        ack_sel = 1'b0;
        dat_sel = '0;
        s_cyc_o = '0;
        s_stb_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == IDX_W'(i)) begin
                ack_sel = s_ack_i[i];
                dat_sel = s_dat_i[WB_DAT_W*i +: WB_DAT_W];
                if (route) begin
                    s_cyc_o[i] = m_cyc_i;
                    s_stb_o[i] = m_stb_i;
                end
            end
        end
    end

    assign m_ack_o = route & req & ack_sel;
    assign m_err_o = !rst && (state_q == ERR);
    assign m_dat_o = (!rst && ((state_q == IDLE && any_hit)
                               || state_q == BUSY)) ? dat_sel : '0;

    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;
    assign err_adr_o   = err_adr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        err_valid_d = err_valid_q & ~err_clr_i;
        err_code_d  = err_code_q;
        err_adr_d   = err_adr_q;
        log_err     = 1'b0;
        log_code    = ERR_UNMAPPED;
        log_adr     = m_adr_i;
        unique case (state_q)
            IDLE: begin
                if (req && any_hit) begin
                    if (!m_ack_o) begin
                        state_d = BUSY;
                        sel_d   = hit_idx;
                        adr_d   = m_adr_i;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (req) begin
                    state_d = ERR;
                    log_err = 1'b1;
                end
            end
            BUSY: begin
                if (!m_cyc_i || m_ack_o) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (WD_EN && cnt_q == CNT_TO) begin
                    state_d  = ERR;
                    cnt_d    = '0;
                    log_err  = 1'b1;
                    log_code = ERR_TIMEOUT;
                    log_adr  = adr_q;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // First error wins and beats a simultaneous clear.
        if (log_err && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_code_d  = log_code;
            err_adr_d   = log_adr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            adr_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_UNMAPPED;
            err_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_adr_q   <= err_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: main 3-slave instance plus
// 1-slave and overlapping 5-slave decode configurations.
module tb_wb_interconnect;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_cyc, m_stb, m_we, err_clr;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_wdat;
    logic [2:0]  s_ack;
    logic [95:0] s_rdat;

    logic [31:0] m_dat;
    logic        m_ack, m_err;
    logic [2:0]  s_cyc, s_stb;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        err_valid, err_code;
    logic [31:0] err_adr;

    logic [31:0] u1_dat, u1_adr, u1_sdat, u1_ea;
    logic        u1_ack, u1_err, u1_we, u1_ev, u1_ec;
    logic [0:0]  u1_cyc, u1_stb;
    logic [3:0]  u1_sel;

    logic [31:0] u5_dat, u5_adr, u5_sdat, u5_ea;
    logic        u5_ack, u5_err, u5_we, u5_ev, u5_ec;
    logic [4:0]  u5_cyc, u5_stb;
    logic [3:0]  u5_sel;

    int n_chk = 0;
    int n_fail = 0;

    assign s_rdat = {32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF};

    wb_interconnect #(
        .NUM_SLAVES(3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_wdat),
        .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .err_valid_o(err_valid), .err_code_o(err_code),
        .err_adr_o(err_adr), .err_clr_i(err_clr)
    );

    wb_interconnect #(
        .NUM_SLAVES(1),
        .SLV_BASE(32'h4000_0000),
        .SLV_MASK(32'hF000_0000),
        .TIMEOUT_CYCLES(0)
    ) u1 (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_wdat),
        .m_dat_o(u1_dat), .m_ack_o(u1_ack), .m_err_o(u1_err),
        .s_cyc_o(u1_cyc), .s_stb_o(u1_stb), .s_we_o(u1_we),
        .s_sel_o(u1_sel), .s_adr_o(u1_adr), .s_dat_o(u1_sdat),
        .s_dat_i(32'h1111_0000), .s_ack_i(1'b1),
        .err_valid_o(u1_ev), .err_code_o(u1_ec),
        .err_adr_o(u1_ea), .err_clr_i(err_clr)
    );

    wb_interconnect #(
        .NUM_SLAVES(5),
        .SLV_BASE({32'h8000_0000, 32'h0000_0000, 32'h0200_FFFC,
                   32'h0200_0000, 32'h0200_0000}),
        .SLV_MASK({32'hF000_0000, 32'h0000_0000, 32'hFFFF_FFFC,
                   32'hFFFF_0000, 32'hFFFF_FFFC}),
        .TIMEOUT_CYCLES(4)
    ) u5 (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_wdat),
        .m_dat_o(u5_dat), .m_ack_o(u5_ack), .m_err_o(u5_err),
        .s_cyc_o(u5_cyc), .s_stb_o(u5_stb), .s_we_o(u5_we),
        .s_sel_o(u5_sel), .s_adr_o(u5_adr), .s_dat_o(u5_sdat),
        .s_dat_i({32'h5555_0004, 32'h5555_0003, 32'h5555_0002,
                  32'h5555_0001, 32'h5555_0000}),
        .s_ack_i(5'b11111),
        .err_valid_o(u5_ev), .err_code_o(u5_ec),
        .err_adr_o(u5_ea), .err_clr_i(err_clr)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; m_cyc = 0; m_stb = 0; m_we = 0; err_clr = 0;
        m_sel = 4'hF; m_adr = '0; m_wdat = '0; s_ack = '0;
        next_cycle(); next_cycle(); mid();
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", m_ack); end
        n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", m_err); end
        n_chk++; if (s_stb !== 3'b000) begin n_fail++; $display("FAIL rst_stb got %b want 000", s_stb); end
        n_chk++; if (s_cyc !== 3'b000) begin n_fail++; $display("FAIL rst_cyc got %b want 000", s_cyc); end
        n_chk++; if (m_dat !== 32'h0) begin n_fail++; $display("FAIL rst_dat got %h want 0", m_dat); end
        n_chk++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ev got %b want 0", err_valid); end
        n_chk++; if (err_adr !== 32'h0) begin n_fail++; $display("FAIL rst_ea got %h want 0", err_adr); end
        next_cycle(); rst = 1'b0;
    endtask

    task automatic test_read_slave0();
        next_cycle();
        m_adr = 32'h8000_0010; m_we = 0; m_cyc = 1; m_stb = 1; s_ack = '0;
        mid();
        n_chk++; if (s_stb !== 3'b001) begin n_fail++; $display("FAIL rd_stb0 got %b want 001", s_stb); end
        n_chk++; if (s_cyc !== 3'b001) begin n_fail++; $display("FAIL rd_cyc0 got %b want 001", s_cyc); end
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack0 got %b want 0", m_ack); end
        next_cycle();
        m_adr = 32'h0201_0000;
        mid();
        n_chk++; if (s_stb !== 3'b001) begin n_fail++; $display("FAIL rd_frozen got %b want 001", s_stb); end
        n_chk++; if (m_dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_frozen_dat got %h want deadbeef", m_dat); end
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack1 got %b want 0", m_ack); end
        next_cycle();
        s_ack = 3'b001;
        mid();
        n_chk++; if (m_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack2 got %b want 1", m_ack); end
        n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL rd_err2 got %b want 0", m_err); end
        n_chk++; if (m_dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_dat got %h want deadbeef", m_dat); end
        next_cycle();
        m_cyc = 0; m_stb = 0; s_ack = '0;
        mid();
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack3 got %b want 0", m_ack); end
        n_chk++; if (s_stb !== 3'b000) begin n_fail++; $display("FAIL rd_stb3 got %b want 000", s_stb); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            m_adr = 32'h0201_0000; m_we = 1; m_cyc = 1; m_stb = 1;
            m_wdat = 32'hC0DE_0000 + k; s_ack = 3'b100;
            mid();
            n_chk++; if (m_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d] got %b want 1", k, m_ack); end
            n_chk++; if (s_stb !== 3'b100) begin n_fail++; $display("FAIL b2b_stb[%0d] got %b want 100", k, s_stb); end
            n_chk++; if (s_wdat !== 32'hC0DE_0000 + k) begin n_fail++; $display("FAIL b2b_wdat[%0d] got %h", k, s_wdat); end
            n_chk++; if (s_we !== 1'b1 || s_adr !== 32'h0201_0000) begin n_fail++; $display("FAIL b2b_bcast[%0d] we %b adr %h", k, s_we, s_adr); end
        end
        next_cycle();
        m_cyc = 0; m_stb = 0; m_we = 0; s_ack = '0;
        mid();
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", m_ack); end
    endtask

    task automatic test_unmapped();
        next_cycle();
        m_adr = 32'h1000_0000; m_cyc = 1; m_stb = 1;
        mid();
        n_chk++; if (s_stb !== 3'b000 || s_cyc !== 3'b000) begin n_fail++; $display("FAIL um_stb got %b/%b want 000", s_stb, s_cyc); end
        n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL um_err0 got %b want 0", m_err); end
        n_chk++; if (m_dat !== 32'h0) begin n_fail++; $display("FAIL um_dat got %h want 0", m_dat); end
        next_cycle(); mid();
        n_chk++; if (m_err !== 1'b1) begin n_fail++; $display("FAIL um_err1 got %b want 1", m_err); end
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL um_ack1 got %b want 0", m_ack); end
        n_chk++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL um_ev got %b want 1", err_valid); end
        n_chk++; if (err_code !== 1'b0) begin n_fail++; $display("FAIL um_ec got %b want 0", err_code); end
        n_chk++; if (err_adr !== 32'h1000_0000) begin n_fail++; $display("FAIL um_ea got %h want 10000000", err_adr); end
        next_cycle();
        m_cyc = 0; m_stb = 0;
        mid();
        n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL um_err2 got %b want 0", m_err); end
    endtask

    task automatic test_timeout();
        next_cycle(); err_clr = 1;
        next_cycle(); err_clr = 0;
        mid();
        n_chk++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL to_clr0 got %b want 0", err_valid); end
        next_cycle();
        m_adr = 32'h0200_4000; m_cyc = 1; m_stb = 1; s_ack = '0;
        mid();
        n_chk++; if (s_stb !== 3'b010) begin n_fail++; $display("FAIL to_stb0 got %b want 010", s_stb); end
        for (int c = 1; c <= 8; c++) begin
            next_cycle(); mid();
            n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL to_early[%0d] got %b want 0", c, m_err); end
            n_chk++; if (s_stb !== 3'b010) begin n_fail++; $display("FAIL to_stb[%0d] got %b want 010", c, s_stb); end
        end
        next_cycle(); mid();
        n_chk++; if (m_err !== 1'b1) begin n_fail++; $display("FAIL to_err9 got %b want 1", m_err); end
        n_chk++; if (s_stb !== 3'b000 || s_cyc !== 3'b000) begin n_fail++; $display("FAIL to_stb9 got %b/%b want 000", s_stb, s_cyc); end
        n_chk++; if (err_valid !== 1'b1 || err_code !== 1'b1) begin n_fail++; $display("FAIL to_log got v%b c%b want v1 c1", err_valid, err_code); end
        n_chk++; if (err_adr !== 32'h0200_4000) begin n_fail++; $display("FAIL to_ea got %h want 02004000", err_adr); end
        next_cycle();
        m_cyc = 0; m_stb = 0;
        mid();
        n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL to_err10 got %b want 0", m_err); end
        next_cycle();
        m_adr = 32'h3000_0000; m_cyc = 1; m_stb = 1;
        next_cycle(); mid();
        n_chk++; if (m_err !== 1'b1) begin n_fail++; $display("FAIL to_um2 got %b want 1", m_err); end
        n_chk++; if (err_adr !== 32'h0200_4000 || err_code !== 1'b1) begin n_fail++; $display("FAIL to_first_wins got %h c%b want 02004000 c1", err_adr, err_code); end
        next_cycle();
        m_cyc = 0; m_stb = 0; err_clr = 1;
        next_cycle(); err_clr = 0;
        mid();
        n_chk++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL to_clr1 got %b want 0", err_valid); end
    endtask

    task automatic test_spurious_abort();
        next_cycle();
        m_adr = 32'h0200_4000; m_cyc = 1; m_stb = 1; s_ack = '0;
        next_cycle();
        s_ack = 3'b001;
        mid();
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL sp_ack0 got %b want 0", m_ack); end
        n_chk++; if (s_stb !== 3'b010) begin n_fail++; $display("FAIL sp_stb got %b want 010", s_stb); end
        next_cycle();
        s_ack = 3'b100;
        mid();
        n_chk++; if (m_ack !== 1'b0) begin n_fail++; $display("FAIL sp_ack2 got %b want 0", m_ack); end
        next_cycle();
        s_ack = '0; m_cyc = 0; m_stb = 0;
        mid();
        n_chk++; if (s_cyc !== 3'b000 || m_ack !== 1'b0) begin n_fail++; $display("FAIL ab_drop cyc %b ack %b want 000 0", s_cyc, m_ack); end
        next_cycle(); mid();
        n_chk++; if (m_err !== 1'b0 || m_ack !== 1'b0) begin n_fail++; $display("FAIL ab_idle err %b ack %b want 0 0", m_err, m_ack); end
        next_cycle();
        m_adr = 32'h1000_0000; m_cyc = 1; m_stb = 1;
        next_cycle();
        s_ack = 3'b111;
        mid();
        n_chk++; if (m_err !== 1'b1 || m_ack !== 1'b0) begin n_fail++; $display("FAIL sp_err err %b ack %b want 1 0", m_err, m_ack); end
        next_cycle();
        m_cyc = 0; m_stb = 0; s_ack = '0;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        m_adr = 32'h0200_4000; m_cyc = 1; m_stb = 1; s_ack = '0;
        next_cycle(); mid();
        n_chk++; if (s_stb !== 3'b010) begin n_fail++; $display("FAIL rm_busy got %b want 010", s_stb); end
        next_cycle(); rst = 1;
        next_cycle(); mid();
        n_chk++; if (s_stb !== 3'b000 || s_cyc !== 3'b000) begin n_fail++; $display("FAIL rm_stb got %b/%b want 000", s_stb, s_cyc); end
        n_chk++; if (m_ack !== 1'b0 || m_err !== 1'b0) begin n_fail++; $display("FAIL rm_resp ack %b err %b want 0 0", m_ack, m_err); end
        n_chk++; if (m_dat !== 32'h0) begin n_fail++; $display("FAIL rm_dat got %h want 0", m_dat); end
        n_chk++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ev got %b want 0", err_valid); end
        next_cycle();
        rst = 0; m_cyc = 0; m_stb = 0;
        mid();
        n_chk++; if (m_err !== 1'b0 || s_cyc !== 3'b000) begin n_fail++; $display("FAIL rm_after err %b cyc %b", m_err, s_cyc); end
        next_cycle();
        m_adr = 32'h0201_0000; m_cyc = 1; m_stb = 1; s_ack = 3'b100;
        mid();
        n_chk++; if (m_ack !== 1'b1 || s_stb !== 3'b100) begin n_fail++; $display("FAIL rm_idle ack %b stb %b want 1 100", m_ack, s_stb); end
        next_cycle();
        m_cyc = 0; m_stb = 0; s_ack = '0;
    endtask

    task automatic test_config();
        next_cycle();
        m_adr = 32'h4000_1234; m_cyc = 1; m_stb = 1; s_ack = 3'b111;
        mid();
        n_chk++; if (u1_stb !== 1'b1 || u1_ack !== 1'b1) begin n_fail++; $display("FAIL n1_hit stb %b ack %b want 1 1", u1_stb, u1_ack); end
        n_chk++; if (u5_stb !== 5'b01000) begin n_fail++; $display("FAIL n5_catch got %b want 01000", u5_stb); end
        next_cycle();
        m_adr = 32'h5000_0000;
        mid();
        n_chk++; if (u1_stb !== 1'b0 || u1_ack !== 1'b0) begin n_fail++; $display("FAIL n1_miss stb %b ack %b want 0 0", u1_stb, u1_ack); end
        next_cycle();
        m_adr = 32'h0200_0000;
        mid();
        n_chk++; if (u1_err !== 1'b1) begin n_fail++; $display("FAIL n1_err got %b want 1", u1_err); end
        n_chk++; if (u5_stb !== 5'b00001) begin n_fail++; $display("FAIL n5_lo got %b want 00001", u5_stb); end
        n_chk++; if (u5_dat !== 32'h5555_0000 || u5_ack !== 1'b1) begin n_fail++; $display("FAIL n5_lo_dat got %h ack %b", u5_dat, u5_ack); end
        next_cycle();
        m_adr = 32'h0200_FFFC;
        mid();
        n_chk++; if (u5_stb !== 5'b00010) begin n_fail++; $display("FAIL n5_hi got %b want 00010", u5_stb); end
        n_chk++; if (u5_dat !== 32'h5555_0001) begin n_fail++; $display("FAIL n5_hi_dat got %h want 55550001", u5_dat); end
        next_cycle();
        m_adr = 32'h9000_0000;
        mid();
        n_chk++; if (u5_stb !== 5'b01000 || u5_dat !== 32'h5555_0003) begin n_fail++; $display("FAIL n5_far stb %b dat %h", u5_stb, u5_dat); end
        next_cycle();
        m_cyc = 0; m_stb = 0; s_ack = '0;
    endtask

    initial begin
        test_reset();
        test_read_slave0();
        test_back_to_back();
        test_unmapped();
        test_timeout();
        test_spurious_abort();
        test_reset_mid();
        test_config();
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Parametrised 1-master to N-slave Wishbone classic interconnect for the SoC core bus.
- Decodes by per-slave base/mask, gates each slave's strobe, muxes the read data and ack back to the master, and holds the selected slave until the cycle ends.
- Adds bus-error responses, which a plain decoder does not provide:
  - unmapped addresses terminate with `m_err`;
  - hung slaves are terminated by a watchdog.
- Sticky error status is captured for firmware and debug.

Parameters:
- `NUM_SLAVES`, 3, number of slave ports (1..16).
- `SLV_BASE`, {32'h0201_0000, 32'h0200_0000, 32'h8000_0000}, flattened `NUM_SLAVES*32`-bit base vector; slave i occupies bits [32*i+31:32*i].
- `SLV_MASK`, {32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_8000}, flattened mask vector with the same layout.
- `TIMEOUT_CYCLES`, 255, cycles without ack before a timeout error; 0 disables the watchdog.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `m_cyc_i` in 1: master cycle.
- `m_stb_i` in 1: master strobe.
- `m_we_i` in 1: master write enable.
- `m_sel_i` in 4: master byte selects.
- `m_adr_i` in 32: master address.
- `m_dat_i` in 32: master write data.
- `m_dat_o` out 32: read data returned to the master.
- `m_ack_o` out 1: ack returned to the master.
- `m_err_o` out 1: bus error returned to the master.
- `s_cyc_o` out NUM_SLAVES: per-slave cycle, `m_cyc_i` gated by selection.
- `s_stb_o` out NUM_SLAVES: per-slave strobe.
- `s_we_o` out 1: broadcast write enable.
- `s_sel_o` out 4: broadcast byte selects.
- `s_adr_o` out 32: broadcast address.
- `s_dat_o` out 32: broadcast write data.
- `s_dat_i` in 32*NUM_SLAVES: slave read data, flattened; slave i at [32*i+31:32*i].
- `s_ack_i` in NUM_SLAVES: slave acks.
- `err_valid_o` out 1: sticky flag, an error has been logged.
- `err_code_o` out 1: 0 = unmapped, 1 = timeout.
- `err_adr_o` out 32: address of the first logged error.
- `err_clr_i` in 1: clears `err_valid_o`; takes effect the next cycle.

Behaviour:
- Reset:
  - `state` = IDLE, watchdog `cnt` = 0, `sel_q` = 0.
  - `err_valid_o` = 0, `err_code_o` = 0, `err_adr_o` = 0.
  - `m_ack_o` = 0, `m_err_o` = 0, `s_cyc_o` = 0, `s_stb_o` = 0, `m_dat_o` = 0.
  - Reset mid-transaction aborts immediately; no ack or err is produced for the aborted cycle.
- Decode (combinational):
  - `hit[i] = ((m_adr_i ^ SLV_BASE[i]) & SLV_MASK[i]) == 0`.
  - `hit_idx` = lowest set bit of `hit` (overlapping windows: lowest index wins).
  - `any_hit` = |hit.
- Broadcast signals (`we`, `sel`, `adr`, `dat`) pass through combinationally with zero latency.
- FSM states: IDLE, BUSY, ERR.
  - **IDLE, request with a hit** (`m_cyc_i & m_stb_i & any_hit`):
    - drive `s_cyc_o[hit_idx]` and `s_stb_o[hit_idx]` in the same cycle;
    - if `s_ack_i[hit_idx]` is high the same cycle, `m_ack_o` = 1 (zero-latency pass-through) and the FSM stays IDLE;
    - otherwise latch `sel_q` = `hit_idx`, set `cnt` = 1, go to BUSY.
  - **IDLE, request with no hit**: drive no slave strobe, latch `err_adr`, go to ERR.
  - **BUSY**:
    - the route is frozen to `sel_q`, even if `m_adr_i` changes;
    - `s_stb_o[sel_q]` = `m_stb_i`, `s_cyc_o[sel_q]` = `m_cyc_i`;
    - `s_ack_i[sel_q]` -> `m_ack_o` = 1 combinationally, go to IDLE, `cnt` = 0;
    - `m_cyc_i` = 0 -> abort to IDLE, `cnt` = 0, no response;
    - `TIMEOUT_CYCLES` != 0 and `cnt` == `TIMEOUT_CYCLES` with no ack -> ERR with code = timeout, and the strobe drops in ERR;
    - otherwise `cnt`++ (width $clog2(TIMEOUT_CYCLES+1), saturating).
  - **ERR**:
    - `m_err_o` = 1 for exactly one cycle, all `s_stb_o`/`s_cyc_o` = 0, `m_dat_o` = 0;
    - next state IDLE (a single forced idle cycle before any new request is accepted).
- Error latency:
  - unmapped: `m_err_o` is asserted 1 cycle after the request;
  - timeout: `m_err_o` is asserted `TIMEOUT_CYCLES`+1 cycles after the request.
- Spurious acks from non-selected slaves are ignored and never reach `m_ack_o`; the same applies to any ack while in ERR.
- `m_ack_o` and `m_err_o` are never asserted together.
- Read mux: `m_dat_o` = `s_dat_i[sel]`, where `sel` = `hit_idx` in IDLE and `sel_q` in BUSY; `m_dat_o` is 0 in ERR or when there is no hit.
- Error log:
  - on entering ERR while `err_valid_o` = 0, set `err_valid_o` and capture `err_code_o` and `err_adr_o`;
  - later errors do not overwrite the log (first error wins).
  - `err_clr_i` clears `err_valid_o`; if an error is logged in the same cycle, the log takes priority.

Decomposition:
- Package `wb_pkg`:
  - `wb_state_e` (IDLE/BUSY/ERR);
  - `ERR_UNMAPPED`/`ERR_TIMEOUT` constants;
  - `WB_ADR_W` = 32, `WB_DAT_W` = 32, `WB_SEL_W` = 4.
- Sub-module `wb_addr_match`: a combinational priority matcher that produces `any_hit` and `hit_idx`, reused by future multi-master arbiters.

Test Plan:
- Slave 0 (0x8000_0000) acks 2 cycles after strobe: read 0x8000_0010 -> `s_stb_o` = 3'b001, `m_ack_o` on cycle 2, `m_dat_o` = slave 0 data 0xDEAD_BEEF.
- Slave 2 (LED) acks the same cycle: write 0x0201_0000 -> zero-latency `m_ack_o`, FSM stays IDLE; back-to-back requests get an ack every cycle.
- Unmapped address 0x1000_0000 -> no `s_stb_o`, `m_err_o` = 1 exactly 1 cycle later; `err_valid_o` = 1, code 0, `err_adr_o` = 0x1000_0000.
- Slave 1 (0x0200_4000) never acks, `TIMEOUT_CYCLES` = 8 -> `m_err_o` at cycle 9, `s_stb_o` drops in the ERR cycle. A second unmapped error does not change `err_adr_o`; `err_clr_i` clears the log.
- Spurious `s_ack_i[0]` while BUSY on slave 1 -> no `m_ack_o`. `m_cyc_i` dropped mid-BUSY -> IDLE, no ack/err. `rst` = 1 mid-BUSY -> all outputs 0 the next cycle.
- `NUM_SLAVES` = 1 and a 5-slave configuration with overlapping masks -> the lowest index is selected, verified at windows 0x0200_0000 and 0x0200_FFFC.
